// File: rtl/universal_shift_reg.sv
// Universal shift register: single-cycle shift/rotate/load commands plus a
// multi-cycle left-shift burst sequenced by a small IDLE/RUN/DONE controller.
module universal_shift_reg #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] In,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [CW-1:0]    amt,
    output logic [WIDTH-1:0] Q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROTL  = 3'b011,
        MODE_ROTR  = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_BURST = 3'b111
    } mode_e;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_e           state, state_next;
    mode_e            op;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt, cnt_next;

    assign op = mode_e'(mode);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statements can leave it unassigned (no latches).
        state_next = state;
        q_next     = Q;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (en) begin
                    case (op)
                        MODE_HOLD:  q_next = Q;
                        MODE_SHL:   q_next = {Q[WIDTH-2:0], sin_r};
                        MODE_SHR:   q_next = {sin_l, Q[WIDTH-1:1]};
                        MODE_ROTL:  q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
                        MODE_ROTR:  q_next = {Q[0], Q[WIDTH-1:1]};
                        MODE_LOAD:  q_next = In;
                        MODE_ASR:   q_next = {Q[WIDTH-1], Q[WIDTH-1:1]};
                        MODE_BURST: begin
                            // A zero-length burst still reports completion.
                            cnt_next   = amt;
                            state_next = (amt == '0) ? S_DONE : S_RUN;
                        end
                        default:    q_next = Q;
                    endcase
                end
            end
            S_RUN: begin
                q_next   = {Q[WIDTH-2:0], sin_r};
                cnt_next = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= S_IDLE;
            Q     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            Q     <= q_next;
            cnt   <= cnt_next;
        end
    end

    assign sout_l = Q[WIDTH-1];
    assign sout_r = Q[0];
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: directed scenarios followed by
// randomized commands compared against an arithmetic reference model.
module tb_universal_shift_reg;

    localparam int W    = 4;
    localparam int CW   = 3;
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic [W-1:0]  In = '0;
    logic          sin_l = 1'b0;
    logic          sin_r = 1'b0;
    logic [CW-1:0] amt = '0;
    logic [W-1:0]  Q;
    logic          sout_l, sout_r, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference model: register value plus the number of burst shifts still owed.
    int m_q    = 0;
    int m_left = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;

    universal_shift_reg #(.WIDTH(W), .CW(CW)) dut (
        .clk(clk), .clr(clr), .en(en), .mode(mode), .In(In),
        .sin_l(sin_l), .sin_r(sin_r), .amt(amt),
        .Q(Q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        int sl, sr;
        sl = int'(sin_l);
        sr = int'(sin_r);
        if (!clr) begin
            m_q = 0; m_left = 0; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_busy) begin
            m_q = ((m_q * 2) + sr) & MASK;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (en) begin
            case (int'(mode))
                1: m_q = ((m_q * 2) + sr) & MASK;
                2: m_q = (m_q / 2) + sl * (1 << (W - 1));
                3: m_q = ((m_q * 2) & MASK) + (m_q / (1 << (W - 1)));
                4: m_q = (m_q / 2) + (m_q % 2) * (1 << (W - 1));
                5: m_q = int'(In);
                6: m_q = (m_q / 2) + (m_q & (1 << (W - 1)));
                7: begin
                    m_left = int'(amt);
                    if (m_left == 0) m_done = 1'b1;
                    else             m_busy = 1'b1;
                end
                default: m_q = m_q;
            endcase
        end
    endtask

    // Advance one clock and move to a sampling point away from the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0; en = 1'b0;
        tick();
        clr = 1'b1; en = 1'b1; mode = 3'b101; In = 4'b1111;
        tick();
        checks++;
        if (Q !== 4'b1111) begin errors++; $display("FAIL reset_preload: Q=%b expected 1111", Q); end
        en = 1'b0; clr = 1'b0;
        tick();
        checks++;
        if (Q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_edge1: Q=%b busy=%b done=%b expected 0000 0 0", Q, busy, done);
        end
        tick();
        checks++;
        if (Q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_edge2: Q=%b busy=%b done=%b expected 0000 0 0", Q, busy, done);
        end
        clr = 1'b1;
    endtask

    task automatic test_shift();
        logic [W-1:0] exp_q [5] = '{4'b1001, 4'b0011, 4'b0001, 4'b0001, 4'b0001};
        en = 1'b1; mode = 3'b101; In = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (Q !== exp_q[i] || sout_l !== exp_q[i][W-1] || sout_r !== exp_q[i][0]) begin
                errors++;
                $display("FAIL shift_step%0d: Q=%b sout_l=%b sout_r=%b expected Q=%b", i, Q, sout_l, sout_r, exp_q[i]);
            end
            case (i)
                0: begin mode = 3'b001; sin_r = 1'b1; end
                1: begin mode = 3'b010; sin_l = 1'b0; end
                default: begin en = 1'b0; mode = 3'b101; In = 4'b1111; end
            endcase
        end
    endtask

    task automatic test_rotate();
        logic [W-1:0] exp_q [4] = '{4'b1010, 4'b0101, 4'b1010, 4'b1101};
        logic [2:0]   ops   [4] = '{3'b101, 3'b011, 3'b100, 3'b110};
        en = 1'b1; In = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            mode = ops[i];
            tick();
            checks++;
            if (Q !== exp_q[i]) begin
                errors++; $display("FAIL rotate_step%0d: Q=%b expected %b", i, Q, exp_q[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_burst();
        logic [W-1:0] exp_q [3] = '{4'b0010, 4'b0100, 4'b1000};
        en = 1'b1; mode = 3'b101; In = 4'b0001;
        tick();
        mode = 3'b111; amt = 3'd3; sin_r = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL burst_busy%0d: busy=%b done=%b expected 1 0", i, busy, done);
            end
            // Commands presented during RUN must have no effect.
            en = i[0]; mode = 3'($urandom_range(0, 6)); In = 4'b1111; amt = 3'd7;
            tick();
            checks++;
            if (Q !== exp_q[i]) begin
                errors++; $display("FAIL burst_q%0d: Q=%b expected %b", i, Q, exp_q[i]);
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL burst_done: busy=%b done=%b expected 0 1", busy, done);
        end
        en = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Q !== 4'b1000) begin
            errors++; $display("FAIL burst_idle: busy=%b done=%b Q=%b expected 0 0 1000", busy, done, Q);
        end
    endtask

    task automatic test_burst_zero();
        en = 1'b1; mode = 3'b111; amt = 3'd0; sin_r = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || Q !== 4'b1000) begin
            errors++; $display("FAIL burst0_done: busy=%b done=%b Q=%b expected 0 1 1000", busy, done, Q);
        end
        en = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Q !== 4'b1000) begin
            errors++; $display("FAIL burst0_idle: busy=%b done=%b Q=%b expected 0 0 1000", busy, done, Q);
        end
    endtask

    task automatic test_burst_abort();
        en = 1'b1; mode = 3'b111; amt = 3'd5; sin_r = 1'b1;
        tick();
        en = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || Q !== 4'b0001) begin
            errors++; $display("FAIL abort_run: busy=%b Q=%b expected 1 0001", busy, Q);
        end
        clr = 1'b0;
        tick();
        checks++;
        if (Q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_reset: Q=%b busy=%b done=%b expected 0000 0 0", Q, busy, done);
        end
        clr = 1'b1;
        tick();
        checks++;
        if (Q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_nodone: Q=%b busy=%b done=%b expected 0000 0 0", Q, busy, done);
        end
        en = 1'b1; mode = 3'b101; In = 4'b0110;
        tick();
        checks++;
        if (Q !== 4'b0110) begin
            errors++; $display("FAIL abort_resume: Q=%b expected 0110", Q);
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr   = ($urandom_range(0, 29) != 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = 3'($urandom_range(0, 7));
            In    = W'($urandom);
            sin_l = 1'($urandom);
            sin_r = 1'($urandom);
            amt   = CW'($urandom);
            tick();
            checks++;
            if (int'(Q) != m_q || busy !== m_busy || done !== m_done ||
                sout_l !== Q[W-1] || sout_r !== Q[0]) begin
                errors++;
                $display("FAIL random%0d: Q=%b busy=%b done=%b expected Q=%0d busy=%0d done=%0d",
                         i, Q, busy, done, m_q, m_busy, m_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_rotate();
        test_burst();
        test_burst_zero();
        test_burst_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
